// File: rtl/pulse_delay_pkg.sv
// Shared definitions for the pulse-delay stage: FSM state encodings and default widths.
// Other delay-path stages and benches import the same constants from here.
package pulse_delay_pkg;

   localparam int DEF_CNT_W  = 8;
   localparam int DEF_MISS_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_PULSE = 2'd2
   } state_e;

endpackage

// File: rtl/pulse_delay_if.sv
// Signal bundle between the upstream d_ff, the pulse-delay stage and its config/status users.
interface pulse_delay_if #(
   parameter int CNT_W  = 8,
   parameter int MISS_W = 8
);
   logic              d;
   logic [CNT_W-1:0]  delay_cfg;
   logic [CNT_W-1:0]  width_cfg;
   logic              q;
   logic              busy;
   logic [MISS_W-1:0] missed_cnt;

   modport master (
      output d, delay_cfg, width_cfg,
      input  q, busy, missed_cnt
   );

   modport slave (
      input  d, delay_cfg, width_cfg,
      output q, busy, missed_cnt
   );
endinterface

// File: rtl/pulse_delay_rise_detect.sv
// Rising-edge detector; the history register loads d during reset so a level held
// high through reset is never reported as an edge.
module rise_detect (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic rise
);
   logic d_prev_q;

   always_ff @(posedge clk) begin
      if (reset) d_prev_q <= d;
      else       d_prev_q <= d;
   end

   assign rise = d & ~d_prev_q;
endmodule

// File: rtl/pulse_delay.sv
// Programmable pulse delay: on each rise of d, wait delay_cfg cycles then pulse q for width_cfg cycles.
// Define PULSE_DELAY_RETRIGGER_EN to let a rise during WAIT restart the delay instead of being dropped.
module pulse_delay
   import pulse_delay_pkg::*;
#(
   parameter int CNT_W  = DEF_CNT_W,
   parameter int MISS_W = DEF_MISS_W
) (
   input  logic         clk,
   input  logic         reset,
   pulse_delay_if.slave bus
);
`ifdef PULSE_DELAY_RETRIGGER_EN
   localparam bit RETRIG = 1'b1;
`else
   localparam bit RETRIG = 1'b0;
`endif

   state_e            state_q, state_d;
   logic              q_q, q_d;
   logic              busy_q;
   logic [CNT_W-1:0]  dcnt_q, dcnt_d;
   logic [CNT_W-1:0]  wcnt_q, wcnt_d;
   logic [CNT_W-1:0]  wlat_q, wlat_d;
   logic [MISS_W-1:0] missed_q, missed_d;
   logic              rise;
   logic              drop;

   // A zero width still produces a one-cycle pulse.
   function automatic logic [CNT_W-1:0] eff_width(input logic [CNT_W-1:0] w);
      return (w == '0) ? CNT_W'(1) : w;
   endfunction

   rise_detect u_rise (
      .clk   (clk),
      .reset (reset),
      .d     (bus.d),
      .rise  (rise)
   );

   always_comb begin
      state_d  = state_q;
      q_d      = q_q;
      dcnt_d   = dcnt_q;
      wcnt_d   = wcnt_q;
      wlat_d   = wlat_q;
      missed_d = missed_q;
      drop     = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (rise) begin
               if (bus.delay_cfg == '0) begin
                  state_d = ST_PULSE;
                  q_d     = 1'b1;
                  wcnt_d  = eff_width(bus.width_cfg) - 1'b1;
               end else begin
                  state_d = ST_WAIT;
                  dcnt_d  = bus.delay_cfg - 1'b1;
                  wlat_d  = eff_width(bus.width_cfg);
               end
            end
         end
         ST_WAIT: begin
            if (RETRIG && rise) begin
               if (bus.delay_cfg == '0) begin
                  state_d = ST_PULSE;
                  q_d     = 1'b1;
                  wcnt_d  = eff_width(bus.width_cfg) - 1'b1;
               end else begin
                  dcnt_d  = bus.delay_cfg - 1'b1;
                  wlat_d  = eff_width(bus.width_cfg);
               end
            end else begin
               drop = rise;
               if (dcnt_q == '0) begin
                  state_d = ST_PULSE;
                  q_d     = 1'b1;
                  wcnt_d  = wlat_q - 1'b1;
               end else begin
                  dcnt_d  = dcnt_q - 1'b1;
               end
            end
         end
         ST_PULSE: begin
            // A rise on the closing edge is still dropped; IDLE only accepts on the next edge.
            drop = rise;
            if (wcnt_q == '0) begin
               state_d = ST_IDLE;
               q_d     = 1'b0;
            end else begin
               wcnt_d  = wcnt_q - 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            q_d     = 1'b0;
         end
      endcase
      if (drop && (missed_q != '1)) missed_d = missed_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         q_q      <= 1'b0;
         busy_q   <= 1'b0;
         dcnt_q   <= '0;
         wcnt_q   <= '0;
         wlat_q   <= '0;
         missed_q <= '0;
      end else begin
         state_q  <= state_d;
         q_q      <= q_d;
         busy_q   <= (state_d != ST_IDLE);
         dcnt_q   <= dcnt_d;
         wcnt_q   <= wcnt_d;
         wlat_q   <= wlat_d;
         missed_q <= missed_d;
      end
   end

   assign bus.q          = q_q;
   assign bus.busy       = busy_q;
   assign bus.missed_cnt = missed_q;
endmodule

// File: tb/tb_pulse_delay.sv
// Directed bench for pulse_delay: a default-width instance and a MISS_W=2 instance share stimulus.
module tb_pulse_delay;
`ifdef PULSE_DELAY_RETRIGGER_EN
   localparam bit RT = 1'b1;
`else
   localparam bit RT = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic       d;
   logic [7:0] delay_cfg;
   logic [7:0] width_cfg;
   int         n_vec = 0;
   int         n_bad = 0;

   pulse_delay_if #(.CNT_W(8), .MISS_W(8)) bus_a ();
   pulse_delay_if #(.CNT_W(8), .MISS_W(2)) bus_b ();

   assign bus_a.d = d;  assign bus_a.delay_cfg = delay_cfg;  assign bus_a.width_cfg = width_cfg;
   assign bus_b.d = d;  assign bus_b.delay_cfg = delay_cfg;  assign bus_b.width_cfg = width_cfg;

   pulse_delay #(.CNT_W(8), .MISS_W(8)) u_dut   (.clk(clk), .reset(reset), .bus(bus_a));
   pulse_delay #(.CNT_W(8), .MISS_W(2)) u_dut_s (.clk(clk), .reset(reset), .bus(bus_b));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Advance n rising edges and settle 1 time unit past the last one.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic dval);
      reset = 1'b1;
      d     = dval;
      step(2);
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; d = 1'b0; delay_cfg = 8'd0; width_cfg = 8'd0;

      // Reset state and basic delay 3 / width 2
      do_reset(1'b0);
      chk("rst_q", bus_a.q, 0);
      chk("rst_busy", bus_a.busy, 0);
      chk("rst_missed", bus_a.missed_cnt, 0);
      delay_cfg = 8'd3; width_cfg = 8'd2; d = 1'b1;
      step(1);  chk("b_k_busy", bus_a.busy, 1);  chk("b_k_q", bus_a.q, 0);
      step(2);  chk("b_k2_q", bus_a.q, 0);
      step(1);  chk("b_k3_q", bus_a.q, 1);
      step(1);  chk("b_k4_q", bus_a.q, 1);  chk("b_k4_busy", bus_a.busy, 1);
      step(1);  chk("b_k5_q", bus_a.q, 0);  chk("b_k5_busy", bus_a.busy, 0);
      chk("b_missed", bus_a.missed_cnt, 0);
      d = 1'b0; step(1);

      // Zero delay, zero width
      do_reset(1'b0);
      delay_cfg = 8'd0; width_cfg = 8'd0; d = 1'b1;
      step(1);  chk("z_k_q", bus_a.q, 1);  chk("z_k_busy", bus_a.busy, 1);
      step(1);  chk("z_k1_q", bus_a.q, 0); chk("z_k1_busy", bus_a.busy, 0);

      // Rise on the edge PULSE returns to IDLE is dropped
      do_reset(1'b0);
      delay_cfg = 8'd0; width_cfg = 8'd2; d = 1'b1;
      step(1);  chk("e_k_q", bus_a.q, 1);
      d = 1'b0;
      step(1);  chk("e_k1_q", bus_a.q, 1);
      d = 1'b1;
      step(1);  chk("e_k2_q", bus_a.q, 0);  chk("e_k2_missed", bus_a.missed_cnt, 1);
      step(1);  chk("e_k3_q", bus_a.q, 0);  chk("e_k3_busy", bus_a.busy, 0);
      d = 1'b0;

      // Dropped (or retriggered) edge during WAIT: rises at edges 10 and 12
      do_reset(1'b0);
      delay_cfg = 8'd5; width_cfg = 8'd1; d = 1'b1;
      step(1); d = 1'b0;
      step(1); d = 1'b1;
      step(1); d = 1'b0;
      step(2);  chk("m_14_q", bus_a.q, 0);
      step(1);  chk("m_15_q", bus_a.q, RT ? 0 : 1);
      step(1);  chk("m_16_q", bus_a.q, 0);
      step(1);  chk("m_17_q", bus_a.q, RT ? 1 : 0);
      step(1);  chk("m_18_q", bus_a.q, 0);
      chk("m_missed", bus_a.missed_cnt, RT ? 0 : 1);

      // Reset mid-pulse with d held high through and after reset
      do_reset(1'b0);
      delay_cfg = 8'd2; width_cfg = 8'd8; d = 1'b1;
      step(3);  chk("r_k2_q", bus_a.q, 1);
      step(1);  chk("r_k3_q", bus_a.q, 1);
      reset = 1'b1;
      step(1);  chk("r_k4_q", bus_a.q, 0);  chk("r_k4_busy", bus_a.busy, 0);
      chk("r_k4_missed", bus_a.missed_cnt, 0);
      step(1);  reset = 1'b0;
      step(4);  chk("r_post_q", bus_a.q, 0);  chk("r_post_busy", bus_a.busy, 0);
      d = 1'b0; step(1);

      // Missed-edge saturation: 6 extra rises inside one long WAIT
      do_reset(1'b0);
      delay_cfg = 8'd200; width_cfg = 8'd1; d = 1'b1;
      step(1);
      for (int i = 0; i < 6; i++) begin
         d = 1'b0; step(1);
         d = 1'b1; step(1);
      end
      chk("s_busy", bus_a.busy, 1);
      chk("s_missed8", bus_a.missed_cnt, RT ? 0 : 6);
      chk("s_missed2", bus_b.missed_cnt, RT ? 0 : 3);

      // Config change in flight has no effect
      do_reset(1'b0);
      delay_cfg = 8'd4; width_cfg = 8'd3; d = 1'b1;
      step(1);
      delay_cfg = 8'd1; width_cfg = 8'd1; d = 1'b0;
      step(3);  chk("c_k3_q", bus_a.q, 0);
      step(1);  chk("c_k4_q", bus_a.q, 1);
      step(2);  chk("c_k6_q", bus_a.q, 1);
      step(1);  chk("c_k7_q", bus_a.q, 0);  chk("c_k7_busy", bus_a.busy, 0);

      // Maximum delay does not wrap
      do_reset(1'b0);
      delay_cfg = 8'd255; width_cfg = 8'd0; d = 1'b1;
      step(1);  d = 1'b0;
      step(254); chk("x_k254_q", bus_a.q, 0);  chk("x_k254_busy", bus_a.busy, 1);
      step(1);   chk("x_k255_q", bus_a.q, 1);
      step(1);   chk("x_k256_q", bus_a.q, 0);  chk("x_k256_busy", bus_a.busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
